// File: rtl/fir_x_feeder_pkg.sv
// Shared constants for the FIR x-sample feeder: register map, CTRL bits,
// FSM encoding and the read-back default value.
package fir_feeder_pkg;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_LEN      = 8'h04;
  localparam logic [7:0] ADDR_STATUS   = 8'h08;
  localparam logic [7:0] ADDR_SENT     = 8'h0C;
  localparam logic [7:0] ADDR_UNDERRUN = 8'h10;
  localparam logic [7:0] ADDR_XDATA    = 8'h40;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } feeder_state_e;

  localparam logic [31:0] RD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/fir_x_feeder_if.sv
// AXI4-Lite MMIO channels plus the outgoing sample stream of the feeder.
// master = CPU/FIR side, slave = the feeder.
interface fir_x_feeder_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   bvalid;
  logic                   bready;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;
  logic                   m_tvalid;
  logic                   m_tready;
  logic [pDATA_WIDTH-1:0] m_tdata;
  logic                   m_tlast;

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready, m_tready,
    input  awready, wready, bvalid, arready, rvalid, rdata, m_tvalid, m_tdata, m_tlast
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready, m_tready,
    output awready, wready, bvalid, arready, rvalid, rdata, m_tvalid, m_tdata, m_tlast
  );

endinterface

// File: rtl/fir_x_feeder_fifo.sv
// First-word-fall-through FIFO with registered storage; i_clear flushes and
// overrides a coincident push or pop.
module fir_sync_fifo #(
  parameter int pWIDTH = 32,
  parameter int pDEPTH = 8
) (
  input  logic                       axis_clk,
  input  logic                       axis_rst_n,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [pWIDTH-1:0]          i_wdata,
  output logic [pWIDTH-1:0]          o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(pDEPTH):0]    o_count
);
  localparam int AW = $clog2(pDEPTH);

  logic [pWIDTH-1:0] r_mem [pDEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == (AW+1)'(pDEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign w_push = i_push && !o_full && !i_clear;
  assign w_pop  = i_pop && !o_empty && !i_clear;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge axis_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/fir_x_feeder.sv
// FIR x-sample feeder: AXI-Lite MMIO pushes samples into a FIFO that streams out.
// Optional UNDERRUN counter at 0x10 built when FIR_X_FEEDER_UNDERRUN_CNT_EN is defined.
//
//   state | meaning
//   IDLE  | after reset or clear, waiting for start
//   RUN   | streaming until the beat with SENT == LEN-1 is accepted
//   DONE  | run finished, leftovers stay buffered for the next start
module fir_x_feeder
  import fir_feeder_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pFIFO_DEPTH = 8
) (
  input logic           axis_clk,
  input logic           axis_rst_n,
  fir_x_feeder_if.slave bus
);
  localparam int CW = $clog2(pFIFO_DEPTH) + 1;

  feeder_state_e          r_state;
  feeder_state_e          w_state_nxt;
  logic                   r_wr_rdy;
  logic                   r_bvalid;
  logic                   r_arready;
  logic                   r_rvalid;
  logic [pDATA_WIDTH-1:0] r_rdata;
  logic [pDATA_WIDTH-1:0] r_len;
  logic [pDATA_WIDTH-1:0] r_sent;
  logic [pDATA_WIDTH-1:0] w_rd_mux;
  logic [pDATA_WIDTH-1:0] w_head;
  logic [CW-1:0]          w_count;
  logic w_full, w_empty, w_aw_xdata, w_wr_go, w_ctrl_wr, w_start, w_clear;
  logic w_start_acc, w_push, w_pop, w_idle, w_busy, w_done, w_tvalid, w_tlast;

  function automatic logic hit(input logic [pADDR_WIDTH-1:0] a, input logic [7:0] off);
    return a == pADDR_WIDTH'(off);
  endfunction

  assign w_aw_xdata  = hit(bus.awaddr, ADDR_XDATA);
  assign w_wr_go     = bus.awvalid && bus.wvalid && !r_bvalid && !r_wr_rdy
                       && !(w_aw_xdata && w_full);
  assign w_ctrl_wr   = r_wr_rdy && hit(bus.awaddr, ADDR_CTRL);
  assign w_start     = w_ctrl_wr && bus.wdata[CTRL_START_BIT];
  assign w_clear     = w_ctrl_wr && bus.wdata[CTRL_CLEAR_BIT];
  assign w_start_acc = w_start && !w_clear && !w_busy;
  assign w_push      = r_wr_rdy && w_aw_xdata;
  assign w_pop       = w_tvalid && bus.m_tready;

  fir_sync_fifo #(.pWIDTH(pDATA_WIDTH), .pDEPTH(pFIFO_DEPTH)) u_fifo (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .i_clear    (w_clear),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_wdata    (bus.wdata),
    .o_rdata    (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (w_start) w_state_nxt = (r_len == '0) ? ST_DONE : ST_RUN;
        ST_RUN:           if (w_pop && w_tlast) w_state_nxt = ST_DONE;
        default:          w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_idle   = (r_state == ST_IDLE);
    w_busy   = (r_state == ST_RUN);
    w_done   = (r_state == ST_DONE);
    w_tvalid = w_busy && !w_empty;
    w_tlast  = w_tvalid && (r_sent == r_len - 1'b1);
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_wr_rdy <= 1'b0;
      r_bvalid <= 1'b0;
      r_len    <= '0;
      r_sent   <= '0;
    end else begin
      r_wr_rdy <= w_wr_go;
      if (r_wr_rdy)         r_bvalid <= 1'b1;
      else if (bus.bready)  r_bvalid <= 1'b0;
      if (r_wr_rdy && hit(bus.awaddr, ADDR_LEN) && !w_busy) r_len <= bus.wdata;
      if (w_clear || w_start_acc) r_sent <= '0;
      else if (w_pop)             r_sent <= r_sent + 1'b1;
    end
  end

`ifdef FIR_X_FEEDER_UNDERRUN_CNT_EN
  logic [31:0] r_underrun;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n)                                  r_underrun <= '0;
    else if (w_clear || w_start_acc)                  r_underrun <= '0;
    else if (w_busy && w_empty && bus.m_tready && (r_underrun != '1))
      r_underrun <= r_underrun + 1'b1;
  end
`endif

  always_comb begin
    w_rd_mux = pDATA_WIDTH'(RD_DEFAULT);
    if (hit(bus.araddr, ADDR_CTRL))
      w_rd_mux = pDATA_WIDTH'({w_done, w_busy, w_idle});
    else if (hit(bus.araddr, ADDR_LEN))
      w_rd_mux = r_len;
    else if (hit(bus.araddr, ADDR_STATUS))
      w_rd_mux = pDATA_WIDTH'({16'(w_count), 14'b0, w_full, w_empty});
    else if (hit(bus.araddr, ADDR_SENT))
      w_rd_mux = r_sent;
`ifdef FIR_X_FEEDER_UNDERRUN_CNT_EN
    else if (hit(bus.araddr, ADDR_UNDERRUN))
      w_rd_mux = pDATA_WIDTH'(r_underrun);
`endif
  end

  // rdata is captured in the arready cycle and frozen until rready.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= pDATA_WIDTH'(RD_DEFAULT);
    end else begin
      r_arready <= bus.arvalid && !r_rvalid && !r_arready;
      if (r_arready) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_mux;
      end else if (r_rvalid && bus.rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign bus.awready  = r_wr_rdy;
  assign bus.wready   = r_wr_rdy;
  assign bus.bvalid   = r_bvalid;
  assign bus.arready  = r_arready;
  assign bus.rvalid   = r_rvalid;
  assign bus.rdata    = r_rdata;
  assign bus.m_tvalid = w_tvalid;
  assign bus.m_tdata  = w_tvalid ? w_head : '0;
  assign bus.m_tlast  = w_tlast;

endmodule

// File: tb/tb_fir_x_feeder.sv
// Self-checking bench for fir_x_feeder: MMIO pushes/reads against a queue model
// of the buffered samples and the per-run beat sequence.
`timescale 1ns/1ps
module tb_fir_x_feeder;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int DEPTH = 8;

  logic axis_clk = 1'b0;
  logic axis_rst_n = 1'b0;
  always #5 axis_clk = ~axis_clk;

  fir_x_feeder_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

  fir_x_feeder #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pFIFO_DEPTH(DEPTH)) dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .bus        (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  beat_t       got_q[$];
  logic [31:0] model_q[$];

  always @(posedge axis_clk) cyc <= cyc + 1;

  always @(negedge axis_clk) begin
    beat_t b;
    if (axis_rst_n && bus.m_tvalid && bus.m_tready) begin
      b.data = bus.m_tdata;
      b.last = bus.m_tlast;
      b.cyc  = cyc;
      got_q.push_back(b);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic bus_write(input logic [11:0] addr, input logic [31:0] data);
    int n;
    bit seen;
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 200) begin
      @(negedge axis_clk);
      if (bus.awready && bus.wready) seen = 1;
      n++;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL write_timeout: addr %h got no awready, required awready within 200 cycles", addr);
    end
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 50) begin
      @(negedge axis_clk);
      if (bus.bvalid) seen = 1;
      n++;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL bvalid_timeout: addr %h got no bvalid, required bvalid", addr);
    end
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] addr, output logic [31:0] data);
    int n;
    bit seen;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 50) begin
      @(negedge axis_clk);
      if (bus.arready) seen = 1;
      n++;
    end
    tick();
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    data = 32'h0;
    if (seen) begin
      seen = 0;
      n = 0;
      while (!seen && n < 50) begin
        @(negedge axis_clk);
        if (bus.rvalid) begin
          seen = 1;
          data = bus.rdata;
        end
        n++;
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL read_timeout: addr %h got no read response, required one", addr);
    end
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic wait_beats(input int n, output bit ok);
    int k = 0;
    while (got_q.size() < n && k < 500) begin
      tick();
      k++;
    end
    ok = (got_q.size() >= n);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0; bus.arvalid = 0; bus.rready = 0;
    bus.awaddr = '0; bus.wdata = '0; bus.araddr = '0; bus.m_tready = 0;
    axis_rst_n = 1'b0;
    repeat (3) @(posedge axis_clk);
    @(negedge axis_clk);
    n_cmp++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.m_tvalid, bus.m_tlast} !== 7'b0
        || bus.m_tdata !== 32'h0 || bus.rdata !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL reset_outputs: got flags %b tdata %h rdata %h, required 0 / 0 / ffffffff",
               {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.m_tvalid, bus.m_tlast},
               bus.m_tdata, bus.rdata);
    end
    tick();
    axis_rst_n = 1'b1;
    tick();
    bus_read(12'h008, rd);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL reset_status: got %h required 00000001", rd); end
    bus_read(12'h000, rd);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL reset_ctrl: got %h required 00000001", rd); end
    bus_read(12'h004, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_len: got %h required 00000000", rd); end
    bus_read(12'h00C, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_sent: got %h required 00000000", rd); end
    bus_read(12'h040, rd);
    n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL xdata_read: got %h required ffffffff", rd); end
    bus_read(12'h03C, rd);
    n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL unmapped_read: got %h required ffffffff", rd); end
    bus_read(12'h010, rd);
`ifdef FIR_X_FEEDER_UNDERRUN_CNT_EN
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_underrun: got %h required 00000000", rd); end
`else
    n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL underrun_absent: got %h required ffffffff", rd); end
`endif
    bus_write(12'h020, 32'h1234);
    bus_read(12'h004, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL unmapped_write: LEN got %h required 00000000", rd); end
  endtask

  task automatic test_prefill();
    logic [31:0] rd;
    logic [31:0] exp;
    bit ok;
    bus.m_tready = 1'b1;
    bus_write(12'h004, 32'd4);
    for (int i = 1; i <= 4; i++) begin
      model_q.push_back(32'(i));
      bus_write(12'h040, 32'(i));
    end
    got_q.delete();
    bus_write(12'h000, 32'h1);
    wait_beats(4, ok);
    n_cmp++;
    if (!ok || got_q.size() != 4) begin
      n_bad++; $display("FAIL prefill_count: got %0d beats required 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp = model_q.pop_front();
        n_cmp++;
        if (got_q[i].data !== exp || got_q[i].last !== (i == 3) || got_q[i].cyc != got_q[0].cyc + i) begin
          n_bad++;
          $display("FAIL prefill_beat%0d: got %h last %b cyc+%0d required %h last %b cyc+%0d",
                   i, got_q[i].data, got_q[i].last, got_q[i].cyc - got_q[0].cyc, exp, (i == 3), i);
        end
      end
    end
    bus.m_tready = 1'b0;
    bus_read(12'h000, rd);
    n_cmp++; if (rd !== 32'h4) begin n_bad++; $display("FAIL prefill_done: got %h required 00000004", rd); end
    bus_read(12'h00C, rd);
    n_cmp++; if (rd !== 32'd4) begin n_bad++; $display("FAIL prefill_sent: got %h required 00000004", rd); end
  endtask

  task automatic test_full_backpressure();
    logic [31:0] rd;
    logic [31:0] exp;
    bit ok;
    bus.m_tready = 1'b0;
    bus_write(12'h004, 32'd9);
    for (int i = 1; i <= DEPTH; i++) begin
      model_q.push_back(32'h100 + 32'(i));
      bus_write(12'h040, 32'h100 + 32'(i));
    end
    bus_read(12'h008, rd);
    n_cmp++; if (rd !== 32'h0008_0002) begin n_bad++; $display("FAIL full_status: got %h required 00080002", rd); end
    bus_write(12'h000, 32'h1);
    bus_read(12'h000, rd);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL full_busy: got %h required 00000002", rd); end
    got_q.delete();
    model_q.push_back(32'h109);
    fork
      bus_write(12'h040, 32'h109);
      begin
        int seen = 0;
        logic [31:0] st;
        repeat (12) begin
          @(negedge axis_clk);
          if (bus.awready) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_bad++; $display("FAIL full_stall: got %0d awready cycles required 0", seen); end
        bus_read(12'h008, st);
        n_cmp++; if (st !== 32'h0008_0002) begin n_bad++; $display("FAIL full_hold: got %h required 00080002", st); end
        bus.m_tready = 1'b1;
      end
    join
    wait_beats(9, ok);
    n_cmp++;
    if (!ok || got_q.size() != 9) begin
      n_bad++; $display("FAIL full_count: got %0d beats required 9", got_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        exp = model_q.pop_front();
        n_cmp++;
        if (got_q[i].data !== exp || got_q[i].last !== (i == 8)) begin
          n_bad++;
          $display("FAIL full_beat%0d: got %h last %b required %h last %b", i, got_q[i].data, got_q[i].last, exp, (i == 8));
        end
      end
    end
    bus.m_tready = 1'b0;
    bus_read(12'h00C, rd);
    n_cmp++; if (rd !== 32'd9) begin n_bad++; $display("FAIL full_sent: got %h required 00000009", rd); end
  endtask

  task automatic test_stream_stall();
    logic [31:0] rd, exp, pd;
    logic        pv, pr, pl;
    bit          pat [12] = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 1, 1, 1};
    bus.m_tready = 1'b0;
    bus_write(12'h004, 32'd4);
    for (int i = 0; i < 4; i++) begin
      exp = $urandom;
      model_q.push_back(exp);
      bus_write(12'h040, exp);
    end
    bus_write(12'h000, 32'h1);
    got_q.delete();
    pv = 0; pr = 0; pd = '0; pl = 0;
    for (int i = 0; i < 12; i++) begin
      bus.m_tready = pat[i];
      @(negedge axis_clk);
      if (pv && !pr) begin
        n_cmp++;
        if (!bus.m_tvalid || bus.m_tdata !== pd || bus.m_tlast !== pl) begin
          n_bad++;
          $display("FAIL stall_hold%0d: got v %b %h last %b required v 1 %h last %b",
                   i, bus.m_tvalid, bus.m_tdata, bus.m_tlast, pd, pl);
        end
      end
      pv = bus.m_tvalid; pr = bus.m_tready; pd = bus.m_tdata; pl = bus.m_tlast;
      tick();
    end
    bus.m_tready = 1'b0;
    n_cmp++;
    if (got_q.size() != 4) begin
      n_bad++; $display("FAIL stall_count: got %0d beats required 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp = model_q.pop_front();
        n_cmp++;
        if (got_q[i].data !== exp || got_q[i].last !== (i == 3)) begin
          n_bad++;
          $display("FAIL stall_beat%0d: got %h last %b required %h last %b", i, got_q[i].data, got_q[i].last, exp, (i == 3));
        end
      end
    end
    bus_read(12'h00C, rd);
    n_cmp++; if (rd !== 32'd4) begin n_bad++; $display("FAIL stall_sent: got %h required 00000004", rd); end
  endtask

  task automatic test_starvation();
    logic [31:0] rd;
    int seen = 0;
    bus.m_tready = 1'b1;
    bus_write(12'h004, 32'd3);
    bus_write(12'h000, 32'h1);
    got_q.delete();
    repeat (6) begin
      @(negedge axis_clk);
      if (bus.m_tvalid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL starve_tvalid: got %0d valid cycles required 0", seen); end
    bus_write(12'h004, 32'd9);
    bus_read(12'h004, rd);
    n_cmp++; if (rd !== 32'd3) begin n_bad++; $display("FAIL len_locked: got %h required 00000003", rd); end
    bus_read(12'h010, rd);
`ifdef FIR_X_FEEDER_UNDERRUN_CNT_EN
    n_cmp++; if (rd == 32'h0 || rd === 32'hFFFF_FFFF) begin n_bad++; $display("FAIL underrun_count: got %h required nonzero count", rd); end
`else
    n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL underrun_absent_run: got %h required ffffffff", rd); end
`endif
    bus_write(12'h040, 32'd7);
    repeat (8) tick();
    n_cmp++;
    if (got_q.size() != 1 || got_q[0].data !== 32'd7 || got_q[0].last !== 1'b0) begin
      n_bad++;
      $display("FAIL starve_beat: got %0d beats first %h, required 1 beat 00000007 last 0",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : 32'hx);
    end
    bus_read(12'h000, rd);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL starve_busy: got %h required 00000002", rd); end
    bus_read(12'h00C, rd);
    n_cmp++; if (rd !== 32'd1) begin n_bad++; $display("FAIL starve_sent: got %h required 00000001", rd); end
    bus.m_tready = 1'b0;
    bus_write(12'h000, 32'h2);
  endtask

  task automatic test_clear_midrun();
    logic [31:0] rd, exp;
    int extra = 0;
    bus.m_tready = 1'b0;
    bus_write(12'h004, 32'd6);
    for (int i = 0; i < 5; i++) begin
      exp = $urandom;
      model_q.push_back(exp);
      bus_write(12'h040, exp);
    end
    bus_write(12'h000, 32'h1);
    got_q.delete();
    bus.m_tready = 1'b1;
    tick();
    tick();
    bus.m_tready = 1'b0;
    n_cmp++;
    if (got_q.size() != 2) begin
      n_bad++; $display("FAIL clear_pre_beats: got %0d beats required 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp = model_q.pop_front();
        n_cmp++;
        if (got_q[i].data !== exp) begin n_bad++; $display("FAIL clear_beat%0d: got %h required %h", i, got_q[i].data, exp); end
      end
    end
    model_q.delete();
    bus_write(12'h000, 32'h2);
    @(negedge axis_clk);
    n_cmp++; if (bus.m_tvalid !== 1'b0) begin n_bad++; $display("FAIL clear_tvalid: got %b required 0", bus.m_tvalid); end
    tick();
    bus.m_tready = 1'b1;
    got_q.delete();
    repeat (3) begin
      @(negedge axis_clk);
      if (bus.m_tvalid) extra++;
    end
    bus.m_tready = 1'b0;
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL clear_silent: got %0d valid cycles required 0", extra); end
    bus_read(12'h000, rd);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL clear_idle: got %h required 00000001", rd); end
    bus_read(12'h008, rd);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL clear_status: got %h required 00000001", rd); end
    bus_read(12'h00C, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL clear_sent: got %h required 00000000", rd); end
    bus_read(12'h004, rd);
    n_cmp++; if (rd !== 32'd6) begin n_bad++; $display("FAIL clear_len: got %h required 00000006", rd); end
  endtask

  task automatic test_random_runs();
    logic [31:0] rd, exp;
    for (int it = 0; it < 3; it++) begin
      int len = $urandom_range(1, 12);
      int pre = $urandom_range(0, (len < DEPTH) ? len : DEPTH);
      bus.m_tready = 1'b0;
      bus_write(12'h004, 32'(len));
      for (int i = 0; i < pre; i++) begin
        exp = $urandom;
        model_q.push_back(exp);
        bus_write(12'h040, exp);
      end
      got_q.delete();
      bus_write(12'h000, 32'h1);
      fork
        begin
          logic [31:0] v;
          for (int i = pre; i < len; i++) begin
            v = $urandom;
            model_q.push_back(v);
            bus_write(12'h040, v);
          end
        end
        begin
          int n = 0;
          while (got_q.size() < len && n < 2000) begin
            bus.m_tready = 1'($urandom_range(0, 1));
            tick();
            n++;
          end
          bus.m_tready = 1'b0;
        end
      join
      n_cmp++;
      if (got_q.size() != len) begin
        n_bad++; $display("FAIL rand%0d_count: got %0d beats required %0d", it, got_q.size(), len);
        model_q.delete();
      end else begin
        for (int i = 0; i < len; i++) begin
          exp = model_q.pop_front();
          n_cmp++;
          if (got_q[i].data !== exp || got_q[i].last !== (i == len - 1)) begin
            n_bad++;
            $display("FAIL rand%0d_beat%0d: got %h last %b required %h last %b",
                     it, i, got_q[i].data, got_q[i].last, exp, (i == len - 1));
          end
        end
      end
      bus_read(12'h00C, rd);
      n_cmp++; if (rd !== 32'(len)) begin n_bad++; $display("FAIL rand%0d_sent: got %h required %h", it, rd, 32'(len)); end
      bus_read(12'h000, rd);
      n_cmp++; if (rd !== 32'h4) begin n_bad++; $display("FAIL rand%0d_done: got %h required 00000004", it, rd); end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    bus.m_tready = 1'b0;
    bus_write(12'h004, 32'd4);
    bus_write(12'h040, 32'hA1);
    bus_write(12'h040, 32'hA2);
    bus_write(12'h000, 32'h1);
    @(negedge axis_clk);
    n_cmp++; if (bus.m_tvalid !== 1'b1) begin n_bad++; $display("FAIL arst_pre_valid: got %b required 1", bus.m_tvalid); end
    #2;
    axis_rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.m_tvalid !== 1'b0) begin n_bad++; $display("FAIL arst_tvalid: got %b required 0", bus.m_tvalid); end
    model_q.delete();
    repeat (2) @(posedge axis_clk);
    #1;
    axis_rst_n = 1'b1;
    tick();
    bus_read(12'h008, rd);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL arst_status: got %h required 00000001", rd); end
    bus_read(12'h004, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL arst_len: got %h required 00000000", rd); end
    bus_read(12'h000, rd);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL arst_idle: got %h required 00000001", rd); end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_full_backpressure();
    test_stream_stall();
    test_starvation();
    test_clear_midrun();
    test_random_runs();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
